// File: rtl/mips64_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips64_pkg
// Description : Shared definitions for the 64-bit integer divide unit:
//               FSM state encoding and default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package mips64_pkg;

    // Default operand / result width of the divider
    localparam int DIV_SIZE_DEFAULT = 64;

    // Divider sequencing states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } div_state_t;

endpackage : mips64_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One restoring shift/trial-subtract/select step. Shifts the
//               next dividend bit into the partial remainder, subtracts the
//               divisor over SIZE+1 bits and keeps the difference only when
//               no borrow occurred. Emits one quotient bit into the LSB.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import mips64_pkg::*;
#(
    parameter int SIZE = DIV_SIZE_DEFAULT
) (
    input  logic [SIZE-1:0] i_rem,
    input  logic [SIZE-1:0] i_quo,
    input  logic [SIZE-1:0] i_divisor,
    output logic [SIZE-1:0] o_rem,
    output logic [SIZE-1:0] o_quo
);

    logic [SIZE:0] w_shift;
    logic [SIZE:0] w_diff;
    logic          w_sel;

    // Partial remainder is always below the divisor, so the SIZE+1-bit
    // difference is negative exactly when its MSB is set.
    always_comb begin
        w_shift = {i_rem, i_quo[SIZE-1]};
        w_diff  = w_shift - {1'b0, i_divisor};
        w_sel   = ~w_diff[SIZE];
        o_rem   = w_sel ? w_diff[SIZE-1:0] : w_shift[SIZE-1:0];
        o_quo   = {i_quo[SIZE-2:0], w_sel};
    end

endmodule : div_step
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module      : div_unit
// Description : Sequential signed/unsigned restoring divider (DDIV/DDIVU).
//               IDLE -> PREP -> CALC (SIZE cycles) -> FIX -> DONE.
//               Optional macro DIV_EARLY_OUT_EN: a zero divisor skips
//               CALC/FIX and goes straight from PREP to DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module div_unit
    import mips64_pkg::*;
#(
    parameter int SIZE = DIV_SIZE_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            is_signed,
    input  logic            flush,
    input  logic [SIZE-1:0] dividend,
    input  logic [SIZE-1:0] divisor,
    output logic            busy,
    output logic            valid,
    output logic [SIZE-1:0] quotient,
    output logic [SIZE-1:0] remainder,
    output logic            div_zero
);

    localparam int                c_CNT_W     = $clog2(SIZE + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(SIZE - 1);

    div_state_t        r_state;
    logic [SIZE-1:0]   r_dvd;       // original dividend, kept for div-by-zero
    logic [SIZE-1:0]   r_dvs;       // original divisor
    logic              r_signed;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [SIZE-1:0]   r_abs_dvs;
    logic [SIZE-1:0]   r_rem;
    logic [SIZE-1:0]   r_quo;
    logic [c_CNT_W-1:0] r_cnt;
    logic              r_valid;
    logic [SIZE-1:0]   r_q_out;
    logic [SIZE-1:0]   r_r_out;
    logic              r_dz_out;

    logic              w_dvd_neg;
    logic              w_dvs_neg;
    logic              w_dvs_zero;
    logic [SIZE-1:0]   w_abs_dvd;
    logic [SIZE-1:0]   w_abs_dvs;
    logic [SIZE-1:0]   w_fix_q;
    logic [SIZE-1:0]   w_fix_r;
    logic [SIZE-1:0]   w_step_rem;
    logic [SIZE-1:0]   w_step_quo;

    // Operand sign/magnitude and final sign correction of the raw results
    always_comb begin
        w_dvd_neg  = r_signed & r_dvd[SIZE-1];
        w_dvs_neg  = r_signed & r_dvs[SIZE-1];
        w_dvs_zero = (r_dvs == '0);
        w_abs_dvd  = w_dvd_neg ? (~r_dvd + 1'b1) : r_dvd;
        w_abs_dvs  = w_dvs_neg ? (~r_dvs + 1'b1) : r_dvs;
        w_fix_q    = r_neg_q ? (~r_quo + 1'b1) : r_quo;
        w_fix_r    = r_neg_r ? (~r_rem + 1'b1) : r_rem;
    end

    div_step #(
        .SIZE      (SIZE)
    ) u_step (
        .i_rem     (r_rem),
        .i_quo     (r_quo),
        .i_divisor (r_abs_dvs),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    // Divider sequencer with registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_signed  <= 1'b0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_abs_dvs <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_q_out   <= '0;
            r_r_out   <= '0;
            r_dz_out  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_dvd    <= dividend;
                        r_dvs    <= divisor;
                        r_signed <= is_signed;
                        r_state  <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r   <= w_dvd_neg;
                        r_quo     <= w_abs_dvd;
                        r_abs_dvs <= w_abs_dvs;
                        r_rem     <= '0;
                        r_cnt     <= '0;
`ifdef DIV_EARLY_OUT_EN
                        if (w_dvs_zero) begin
                            r_q_out  <= '1;
                            r_r_out  <= r_dvd;
                            r_dz_out <= 1'b1;
                            r_valid  <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state <= ST_CALC;
                        end
`else
                        r_state <= ST_CALC;
`endif
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_rem <= w_step_rem;
                        r_quo <= w_step_quo;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_LAST_STEP) begin
                            r_state <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else begin
                        // Zero divisor: architectural result overrides the raw datapath
                        if (w_dvs_zero) begin
                            r_q_out  <= '1;
                            r_r_out  <= r_dvd;
                            r_dz_out <= 1'b1;
                        end else begin
                            r_q_out  <= w_fix_q;
                            r_r_out  <= w_fix_r;
                            r_dz_out <= 1'b0;
                        end
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign valid     = r_valid;
    assign quotient  = r_q_out;
    assign remainder = r_r_out;
    assign div_zero  = r_dz_out;

endmodule : div_unit
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_unit
// Description : Self-checking bench for div_unit (SIZE=64). A transaction-
//               level reference model predicts results and the cycle of the
//               valid pulse; a compare process checks every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    localparam int N = 64;
    localparam logic [N-1:0] c_MIN  = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0] c_ONES = {N{1'b1}};

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         is_signed;
    logic         flush;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         valid;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_zero;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic         m_live  = 1'b0;
    int           m_cnt   = 0;
    int           m_due   = 0;
    logic         m_valid = 1'b0;
    logic [N-1:0] m_q     = '0;
    logic [N-1:0] m_r     = '0;
    logic         m_dz    = 1'b0;
    logic [N-1:0] p_q, p_r;
    logic         p_dz;

    div_unit #(.SIZE(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .flush     (flush),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .valid     (valid),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of a divide, straight from the instruction rules
    task automatic ref_div(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                           output logic [N-1:0] q, output logic [N-1:0] r, output logic dz);
        dz = 1'b0;
        if (b == '0) begin
            q = c_ONES; r = a; dz = 1'b1;
        end else if (!s) begin
            q = a / b; r = a % b;
        end else if (a == c_MIN && b == c_ONES) begin
            q = c_MIN; r = '0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
    endtask

    function automatic int latency_for(input logic [N-1:0] b);
`ifdef DIV_EARLY_OUT_EN
        if (b == '0) return 1;
`endif
        return N + 2;
    endfunction

    // Transaction-level model: accept, cancel, deliver on the due edge
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_live = 1'b0; m_valid = 1'b0;
                m_q = '0; m_r = '0; m_dz = 1'b0;
            end else begin
                m_valid = 1'b0;
                if (m_live) begin
                    if (flush && m_cnt < m_due) begin
                        m_live = 1'b0;
                    end else begin
                        m_cnt++;
                        if (m_cnt == m_due) begin
                            m_valid = 1'b1; m_q = p_q; m_r = p_r; m_dz = p_dz;
                        end else if (m_cnt == m_due + 1) begin
                            m_live = 1'b0;
                        end
                    end
                end else if (start) begin
                    m_live = 1'b1;
                    m_cnt  = 0;
                    m_due  = latency_for(divisor);
                    ref_div(dividend, divisor, is_signed, p_q, p_r, p_dz);
                end
            end
        end
    end

    // Per-cycle comparison, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            chk("valid", {63'd0, valid}, {63'd0, m_valid});
            chk("busy", {63'd0, busy}, {63'd0, m_live});
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
            chk("div_zero", {63'd0, div_zero}, {63'd0, m_dz});
        end
    end

    // Issue one divide and wait (bounded) for its valid pulse
    task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                          output int lat);
        @(negedge clk);
        dividend = a; divisor = b; is_signed = s; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        dividend = {$urandom, $urandom};
        divisor  = {$urandom, $urandom};
        is_signed = 1'($urandom);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (valid) break;
        end
        if (!valid) chk("valid_timeout", {63'd0, valid}, 64'd1);
        for (int k = 0; k < 10 && busy; k++) @(negedge clk);
    endtask

    task automatic run_lit(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic s, input logic [N-1:0] eq, input logic [N-1:0] er,
                           input logic edz, input int elat);
        int lat;
        run_op(a, b, s, lat);
        chk({name, "_q"}, quotient, eq);
        chk({name, "_r"}, remainder, er);
        chk({name, "_dz"}, {63'd0, div_zero}, {63'd0, edz});
        chk({name, "_lat"}, 64'(lat), 64'(elat));
    endtask

    initial begin
        int lat;
        int vcnt;
        logic [N-1:0] a, b;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; is_signed = 1'b0;
        dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("rst_q", quotient, '0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        rst_n = 1'b1;

        // Hand-computed expectations
        run_lit("u100_7", 64'd100, 64'd7, 1'b0, 64'd14, 64'd2, 1'b0, 66);
        run_lit("s-7_2", -64'sd7, 64'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 66);
        run_lit("s7_-2", 64'd7, -64'sd2, 1'b1, -64'sd3, 64'd1, 1'b0, 66);
        run_lit("minneg", c_MIN, c_ONES, 1'b1, c_MIN, '0, 1'b0, 66);
        run_lit("ones_1", c_ONES, 64'd1, 1'b0, c_ONES, '0, 1'b0, 66);
        run_lit("u5_0", 64'd5, '0, 1'b0, c_ONES, 64'd5, 1'b1, latency_for('0));

        // Second start ignored at edge 10, flush at edge 30
        @(negedge clk);
        dividend = 64'd1000; divisor = 64'd9; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vcnt = 0;
        for (int k = 1; k <= 40; k++) begin
            start = (k == 10);
            flush = (k == 30);
            dividend = 64'd77; divisor = 64'd5;
            @(posedge clk);
            #1;
            if (valid) vcnt++;
            @(negedge clk);
        end
        start = 1'b0; flush = 1'b0;
        chk("flush_no_valid", 64'(vcnt), 64'd0);
        chk("flush_hold_q", quotient, c_ONES);
        chk("flush_hold_r", remainder, 64'd5);
        run_lit("u9_3", 64'd9, 64'd3, 1'b0, 64'd3, '0, 1'b0, 66);

        // Reset in the middle of an operation
        @(negedge clk);
        dividend = 64'd12345; divisor = 64'd11; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_q", quotient, '0);
        chk("rst_mid_r", remainder, '0);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_valid", {63'd0, valid}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_lit("after_rst", -64'sd100, 64'd7, 1'b1, -64'sd14, -64'sd2, 1'b0, 66);

        // Randomized operations checked by the model
        for (int i = 0; i < 24; i++) begin
            a = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: b = {$urandom, $urandom};
                1: b = 64'($urandom_range(1, 15));
                2: b = '0;
                3: b = c_ONES;
                default: b = -64'($urandom_range(1, 1000));
            endcase
            if ($urandom_range(0, 5) == 0) a = c_MIN;
            run_op(a, b, 1'($urandom), lat);
            chk("rand_lat", 64'(lat), 64'(latency_for(b)));
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_div_unit
`default_nettype wire
